// File: rtl/fifo_uart_tx.sv
// Drains a 16-bit synchronous FIFO onto an 8N1 UART line, two bytes per word, low byte first.
// One word is in flight at a time; completed words are counted in words_sent.
module fifo_uart_tx #(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              byte_sel_q, byte_sel_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              tx_q, tx_d;
    logic              fifo_rd_en_q, fifo_rd_en_d;
    logic              busy_q, busy_d;
    logic [15:0]       words_sent_q, words_sent_d;

    logic              baud_tick;
    logic [7:0]        cur_byte;

    assign baud_tick = (cnt_q == CNT_MAX);
    assign cur_byte  = byte_sel_q ? word_q[15:8] : word_q[7:0];

    // tx_d is a function of the current state, so the line lags the FSM by one cycle;
    // this gives the 3-cycle pop-to-start-bit latency and 3 idle-high cycles between words.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d        = state_q;
        cnt_d          = cnt_q + 1'b1;
        bit_idx_d      = bit_idx_q;
        byte_sel_d     = byte_sel_q;
        word_d         = word_q;
        tx_d           = 1'b1;
        fifo_rd_en_d   = 1'b0;
        busy_d         = busy_q;
        words_sent_d   = words_sent_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_rd_en_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = POP;
                end
            end
            POP: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                cnt_d      = '0;
                word_d     = fifo_dout;
                byte_sel_d = 1'b0;
                state_d    = START;
            end
            START: begin
                tx_d = 1'b0;
                if (baud_tick) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx_d = cur_byte[bit_idx_q];
                if (baud_tick) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        words_sent_d = words_sent_q + 16'd1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the word register is reset too, so a mid-frame reset leaves no stale data behind.
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            byte_sel_q   <= 1'b0;
            word_q       <= '0;
            tx_q         <= 1'b1;
            fifo_rd_en_q <= 1'b0;
            busy_q       <= 1'b0;
            words_sent_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_sel_q   <= byte_sel_d;
            word_q       <= word_d;
            tx_q         <= tx_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            busy_q       <= busy_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4: reset, single word, back-to-back,
// empty guard, mid-frame reset and words_sent wrap.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_dout = 16'h0000;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    fifo_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    // FIFO model: main writes mem/wr_ptr, the model owns rd_ptr/dout/empty.
    logic [15:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    always @(posedge clk) begin : fifo_model
        logic pop_req;
        pop_req = fifo_rd_en;
        #1;
        if (pop_req === 1'b1 && rd_ptr != wr_ptr) begin
            fifo_dout = mem[rd_ptr];
            rd_ptr++;
        end
        fifo_empty = (rd_ptr == wr_ptr);
    end

    // Line monitor: one tx sample per cycle plus pulse bookkeeping.
    logic tx_log [$];
    int   pulse_idx [$];
    int   rd_count   = 0;
    int   guard_viol = 0;
    int   pulse_viol = 0;
    logic last_empty = 1'b1;
    logic last_rd    = 1'b0;

    always @(negedge clk) begin
        tx_log.push_back(tx);
        if (fifo_rd_en === 1'b1) begin
            rd_count++;
            pulse_idx.push_back(tx_log.size() - 1);
            if (last_empty !== 1'b0) guard_viol++;
            if (last_rd === 1'b1) pulse_viol++;
        end
        last_empty = fifo_empty;
        last_rd    = fifo_rd_en;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        @(posedge clk);
        #2;
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_words(input string tag, input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (words_sent !== target && n < budget) begin
            tick();
            n++;
        end
        check(tag, words_sent, target);
    endtask

    logic [7:0] rx [$];

    task automatic decode(input int from);
        int         i;
        logic [7:0] b;
        rx.delete();
        i = from;
        while (i + 39 < tx_log.size()) begin
            if (tx_log[i] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = tx_log[i + CPB * (k + 1) + 2];
                check("stop_bit", tx_log[i + 38], 1);
                rx.push_back(b);
                i += 40;
            end else begin
                i++;
            end
        end
    endtask

    function automatic logic [31:0] rx_at(input int k);
        return (k < rx.size()) ? {24'h0, rx[k]} : 32'hDEAD;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         lb, pb, base, zeros, f, gap;
        logic [19:0] t2_bits;
        logic [3:0]  obs4;
        logic [7:0]  t3_exp [0:5];

        // 1: reset and idle with an empty FIFO
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_words", words_sent, 16'h0);
        lb = tx_log.size();
        repeat (100) tick();
        zeros = 0;
        for (int i = lb; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) zeros++;
        check("idle_tx_high", zeros, 0);
        check("idle_no_pop", rd_count, 0);
        check("idle_busy", busy, 0);

        // 2: single word A55A, exact line pattern
        lb   = tx_log.size();
        pb   = pulse_idx.size();
        base = rd_count;
        push(16'hA55A);
        tick();
        wait_words("t2_words", 16'd1, 200);
        repeat (4) tick();
        check("t2_pulses", rd_count - base, 1);
        check("t2_busy", busy, 0);
        check("t2_tx_idle", tx, 1);
        f = -1;
        for (int i = lb; i < tx_log.size(); i++) begin
            if (f < 0 && tx_log[i] === 1'b0) f = i;
        end
        check("t2_rd_to_tx", (pb < pulse_idx.size() && f >= 0) ? f - pulse_idx[pb] : -1, 3);
        t2_bits = 20'b0010110101_0101001011;
        for (int j = 0; j < 20; j++) begin
            for (int s = 0; s < 4; s++)
                obs4[s] = (f >= 0 && f + 4 * j + s < tx_log.size()) ? tx_log[f + 4 * j + s] : 1'bx;
            check($sformatf("t2_bit%0d", j), obs4, {4{t2_bits[19 - j]}});
        end

        // 3: back-to-back words
        lb   = tx_log.size();
        pb   = pulse_idx.size();
        base = rd_count;
        push(16'h0001);
        push(16'hFFFF);
        push(16'h8000);
        tick();
        wait_words("t3_words", 16'd4, 600);
        repeat (50) tick();
        check("t3_pulses", rd_count - base, 3);
        for (int k = 0; k < 2; k++) begin
            gap = (pb + k + 1 < pulse_idx.size()) ? pulse_idx[pb + k + 1] - pulse_idx[pb + k] : 0;
            check($sformatf("t3_gap%0d", k), gap >= 83, 1);
        end
        decode(lb);
        t3_exp[0] = 8'h01; t3_exp[1] = 8'h00; t3_exp[2] = 8'hFF;
        t3_exp[3] = 8'hFF; t3_exp[4] = 8'h00; t3_exp[5] = 8'h80;
        check("t3_nbytes", rx.size(), 6);
        for (int k = 0; k < 6; k++) check($sformatf("t3_byte%0d", k), rx_at(k), {24'h0, t3_exp[k]});

        // 4: empty guard
        base = rd_count;
        repeat (200) tick();
        check("t4_no_pop", rd_count - base, 0);
        check("t4_tx", tx, 1);
        check("t4_busy", busy, 0);

        // 5: reset during DATA bit 3 of the low byte
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_pre_words", words_sent, 16'h0);
        push(16'h1234);
        push(16'hC3C3);
        tick();
        begin
            int n;
            n = 0;
            while (fifo_rd_en !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
        end
        check("t5_pop_seen", fifo_rd_en, 1);
        repeat (19) tick();
        check("t5_bit3_tx", tx, 0);
        rst = 1'b0;
        tick();
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_words", words_sent, 16'h0);
        check("t5_rst_rd_en", fifo_rd_en, 0);
        rst = 1'b1;
        lb = tx_log.size();
        wait_words("t5_words", 16'd1, 300);
        repeat (5) tick();
        decode(lb);
        check("t5_nbytes", rx.size(), 2);
        check("t5_byte0", rx_at(0), 32'hC3);
        check("t5_byte1", rx_at(1), 32'hC3);

        // 6: words_sent wrap
        tick();
        force dut.words_sent_q = 16'hFFFF;
        tick();
        release dut.words_sent_q;
        tick();
        check("t6_preset", words_sent, 16'hFFFF);
        push(16'h0F0F);
        tick();
        wait_words("t6_wrap", 16'h0000, 300);
        repeat (3) tick();
        check("t6_words_hold", words_sent, 16'h0000);
        check("t6_busy", busy, 0);

        check("rd_en_guard", guard_viol, 0);
        check("rd_en_width", pulse_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
